dmem_write_buffer: RTL

//  Posted-store buffer between the ARM pipeline's data port and the data memory.

---
 rtl/dmem_write_buffer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dmem_write_buffer.sv
// -----------------------------------------------------------------------------
// dmem_write_buffer
//
// Posted-store buffer that sits between the core's data port and data memory.
// Stores are queued in a small FIFO and retired to memory on cycles where the
// core is not reading. Loads search the queue, so a load that follows a
// buffered store to the same word observes the new data.
//
// Build option:
//   WB_FORWARD_EN  defined   : a load that hits the queue is served directly
//                              from the newest matching entry, with no stall.
//                  undefined : a load that hits the queue stalls, and the
//                              memory port drains the queue until no matching
//                              entry is left. The load then reads memory.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   cpu_we     core store request
//   cpu_re     core load request (never asserted together with cpu_we)
//   cpu_adr    core byte address; entries match on word bits [WIDTH-1:2]
//   cpu_wd     core store data
//   cpu_rd     load data returned to the core
//   cpu_stall  core must hold its request this cycle
//   mem_we     data memory write enable
//   mem_adr    data memory address
//   mem_wd     data memory write data
//   mem_rd     data memory read data (combinational on mem_adr)
//   mem_ready  data memory accepts the write this cycle
// -----------------------------------------------------------------------------
module dmem_write_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4    // power of 2, >= 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_we,
    input  logic             cpu_re,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic [WIDTH-1:0] cpu_rd,
    output logic             cpu_stall,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd,
    input  logic             mem_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] adr_q  [DEPTH];
    logic [WIDTH-1:0] adr_d  [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    logic             hit;
    logic [PW-1:0]    slot;
    logic             load_block;
    logic             drain_own;
    logic             push;
    logic             pop;
`ifdef WB_FORWARD_EN
    logic [WIDTH-1:0] hit_data;
`endif

    // Queue search, walked oldest to newest so the newest match is the last
    // one written and therefore the one that wins.
    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        hit  = 1'b0;
        slot = '0;
`ifdef WB_FORWARD_EN
        hit_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) &&
                (adr_q[slot][WIDTH-1:2] == cpu_adr[WIDTH-1:2])) begin
                hit = 1'b1;
`ifdef WB_FORWARD_EN
                hit_data = data_q[slot];
`endif
            end
        end
    end

    // Port ownership, stall and push/pop decisions.
    always_comb begin
`ifdef WB_FORWARD_EN
        load_block = 1'b0;
        cpu_rd     = hit ? hit_data : mem_rd;
`else
        // A load that hits the queue waits and lends the port to the drain.
        load_block = cpu_re & hit;
        cpu_rd     = mem_rd;
`endif
        drain_own = ~cpu_re | load_block;
        mem_we    = drain_own & (count_q != '0);
        mem_adr   = drain_own ? adr_q[rd_ptr_q] : cpu_adr;
        mem_wd    = data_q[rd_ptr_q];
        pop       = mem_we & mem_ready;
        // A full queue still accepts a store when the head retires this cycle.
        cpu_stall = (cpu_we & (count_q == CW'(DEPTH)) & ~pop) | load_block;
        push      = cpu_we & ~cpu_stall;
    end

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        adr_d    = adr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            adr_d[wr_ptr_q]  = cpu_adr;
            data_d[wr_ptr_q] = cpu_wd;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: entry storage is cleared on reset as well, so an abandoned
            // store can never reappear through the head or a load search.
            for (int i = 0; i < DEPTH; i++) begin
                adr_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            adr_q    <= adr_d;
            data_q   <= data_d;
        end
    end

    // A store and a load in the same cycle is not a legal core request.
    a_no_we_and_re: assert property (@(posedge clk) disable iff (!reset)
        !(cpu_we && cpu_re));

endmodule
